// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed from latched operands and committed atomically as busy falls.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        signed_q, signed_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // Operation path, driven purely by the latched operands.
  logic [63:0] mul_a, mul_b, product;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    mul_a   = {{32{signed_q & a_q[31]}}, a_q};
    mul_b   = {{32{signed_q & b_q[31]}}, b_q};
    product = mul_a * mul_b;
    a_neg   = signed_q & a_q[31];
    b_neg   = signed_q & b_q[31];
    a_mag   = a_neg ? (32'd0 - a_q) : a_q;
    b_mag   = b_neg ? (32'd0 - b_q) : b_q;
    q_mag   = a_mag / b_mag;
    r_mag   = a_mag % b_mag;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Handshake: start is a one-cycle request, accepted only on an edge where
  // busy = 0; there is no back-pressure, so a request seen while busy is dropped.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd1, 3'd2: begin
              state_d  = MUL;
              cnt_d    = 4'd5;
              a_d      = a;
              b_d      = b;
              signed_d = (op == 3'd1);
            end
            3'd3, 3'd4: begin
              state_d  = DIV;
              cnt_d    = 4'd10;
              a_d      = a;
              b_d      = b;
              signed_d = (op == 3'd3);
            end
            3'd5:    hi_d = a;
            3'd6:    lo_d = a;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (state_q == MUL) begin
            hi_d = product[63:32];
            lo_d = product[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      signed_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, ignored requests and mid-op reset.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue an op, count busy cycles while checking HI/LO hold, then check the commit.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start = 1'b1; op = o; a = av; b = bv;
    tick;
    start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      check({tag, "_hold_hi"}, hi, m_hi);
      check({tag, "_hold_lo"}, lo, m_lo);
      n++;
      tick;
    end
    check({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    m_hi = exp_hi;
    m_lo = exp_lo;
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  task automatic move_to(input string tag, input logic [2:0] o, input logic [31:0] av);
    start = 1'b1; op = o; a = av; b = 32'h0;
    tick;
    start = 1'b0; op = 3'd0; a = 32'h0;
    if (o == 3'd5) m_hi = av;
    if (o == 3'd6) m_lo = av;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    reset = 1'b0;
    tick;

    run_op("mult", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);

    move_to("mthi_11", 3'd5, 32'h11);
    move_to("mtlo_22", 3'd6, 32'h22);
    run_op("divu_zero", 3'd4, 32'd50, 32'd0, 10, 32'h11, 32'h22);
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    move_to("mthi_abcd", 3'd5, 32'hABCD);
    move_to("mtlo_5678", 3'd6, 32'h5678);

    // Ops 0 and 7 do nothing.
    move_to("nop0", 3'd0, 32'hDEAD);
    move_to("nop7", 3'd7, 32'hBEEF);

    // mthi arriving on cycle 3 of a mult is dropped.
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    tick;
    start = 1'b0; op = 3'd0;
    tick;
    tick;
    start = 1'b1; op = 3'd5; a = 32'h1234;
    tick;
    start = 1'b0; op = 3'd0; a = 32'h0;
    check("mid_mthi_hold_hi", hi, m_hi);
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      tick;
    end
    check("mid_mthi_cycles", 32'(n), 32'd2);
    m_hi = 32'h0; m_lo = 32'd12;
    check("mid_mthi_hi", hi, m_hi);
    check("mid_mthi_lo", lo, m_lo);

    // mtlo presented on the commit edge is dropped.
    start = 1'b1; op = 3'd2; a = 32'd5; b = 32'd6;
    tick;
    start = 1'b0; op = 3'd0;
    repeat (4) tick;
    check("commit_pre_busy", 32'(busy), 32'd1);
    start = 1'b1; op = 3'd6; a = 32'h9999;
    tick;
    start = 1'b0; op = 3'd0; a = 32'h0;
    m_hi = 32'h0; m_lo = 32'd30;
    check("commit_busy", 32'(busy), 32'd0);
    check("commit_hi", hi, m_hi);
    check("commit_lo", lo, m_lo);
    tick;
    check("commit_after_lo", lo, m_lo);
    move_to("first_free_mtlo", 3'd6, 32'h77);
    move_to("mthi_55", 3'd5, 32'h55);

    // Reset between edges on cycle 4 of a div aborts it.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    tick;
    start = 1'b0; op = 3'd0;
    repeat (3) tick;
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    #1;
    reset = 1'b0;
    repeat (12) tick;
    m_hi = 32'h0; m_lo = 32'h0;
    check("rst_after_busy", 32'(busy), 32'd0);
    check("rst_after_hi", hi, m_hi);
    check("rst_after_lo", lo, m_lo);

    run_op("post_rst_mult", 3'd1, 32'd3, 32'd4, 5, 32'h0, 32'd12);
    run_op("neg_mult", 3'd1, 32'hFFFFFFFD, 32'hFFFFFFFC, 5, 32'h0, 32'd12);
    run_op("div_rem", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request pulse from the E stage.
REQ-004 SHALL have port op, input, 3 bits: operation code. 0 = none, 1 = mult, 2 = multu, 3 = div, 4 = divu, 5 = mthi, 6 = mtlo, 7 = none.
REQ-005 SHALL have port a, input, 32 bits: rs operand (dividend or multiplicand).
REQ-006 SHALL have port b, input, 32 bits: rt operand (divisor or multiplier).
REQ-007 SHALL have port busy, output, 1 bit: an operation is in flight; the D-stage stall logic consumes it.
REQ-008 SHALL have port hi, output, 32 bits: architectural HI register.
REQ-009 SHALL have port lo, output, 32 bits: architectural LO register.

Function
REQ-010 SHALL implement three states: IDLE, MUL and DIV; busy = 1 exactly when the state is not IDLE.
REQ-011 In IDLE, start=1 with op 1 or 2 SHALL latch a and b, enter MUL, and load the cycle counter with 5.
REQ-012 In IDLE, start=1 with op 3 or 4 SHALL latch a and b, enter DIV, and load the counter with 10.
REQ-013 In IDLE, start=1 with op 5 (mthi) or 6 (mtlo) SHALL write a into hi or lo on the same edge; busy stays 0.
REQ-014 start=1 with op 0 or 7 SHALL have no effect.
REQ-015 The counter SHALL decrement once per cycle in MUL or DIV. At the edge where the counter equals 1:
- commit the result to hi and lo;
- return to IDLE.
REQ-016 busy SHALL therefore be high for exactly 5 cycles (mult/multu) or 10 cycles (div/divu) after the start edge.
REQ-017 hi and lo SHALL hold their previous values for the whole time busy is high; the commit is atomic on the falling edge of busy.
REQ-018 start SHALL be ignored while busy = 1, including ops 5 and 6. Latched operands SHALL NOT change mid-operation.
REQ-019 mult SHALL form the signed 32x32 -> 64-bit product; multu SHALL form the unsigned product. {hi, lo} = product.
REQ-020 div and divu (signed and unsigned) SHALL set lo = quotient (truncated toward zero) and hi = remainder (same sign as the dividend).
REQ-021 Signed div 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0x00000000, with no trap.
REQ-022 Divide by zero (b = 0) SHALL still hold busy for 10 cycles, then leave hi and lo unchanged.
REQ-023 A start arriving in the same cycle as the commit edge SHALL be ignored, because busy is still 1 in that cycle. A new operation MAY start on the first cycle with busy = 0.
REQ-024 The block SHALL NOT depend on pipeline stall or flush. The E-stage instruction that issues start is never stalled, because stalls occur only in D.

Reset
REQ-025 While reset = 1, asynchronously and regardless of clk, the block SHALL force:
- state = IDLE, so busy = 0;
- counter = 0;
- hi = 0 and lo = 0;
- latched operands = 0.
REQ-026 Reset asserted mid-operation SHALL abort it: no commit follows reset release.
REQ-027 After reset release, the first rising edge with start = 1 SHALL be accepted normally.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- mult with a = 0xFFFFFFFF, b = 2 -> busy high 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. multu with the same operands -> hi = 0x00000001, lo = 0xFFFFFFFE.
- div with a = 0xFFFFFFF9 (-7), b = 2 -> busy high 10 cycles, then lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu with a = 7, b = 2 -> lo = 3, hi = 1.
- divu with b = 0 after hi = 0x11, lo = 0x22 -> busy high 10 cycles, then hi = 0x11, lo = 0x22. Signed 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
- mult started, then start with op = mthi and a = 0x1234 on cycle 3 -> ignored; only the mult result appears after 5 cycles. start in the commit cycle -> ignored.
- mthi with a = 0xABCD in IDLE -> hi = 0xABCD after one edge, busy stays 0, lo unchanged. mtlo follows the same pattern for lo.
- div started, reset asserted on cycle 4 between clock edges -> busy, hi and lo go to 0 immediately; after release, busy stays 0 and no commit occurs.
